shift_seq_ctrl: RTL and testbench

Command-driven sequencer for the team's 4-bit `bi_shift_register`. It accepts load, shift and rotate commands over a valid/ready handshake and drives the register's mode select, serial inputs and parallel data for the required number of cycles. It also streams out the bit shifted off the register each cycle and pulses `done` when the command completes. It sits between a host command source and the bi-directional shift register, and reads back the register's parallel output for rotation and serial output.

---
 rtl/shift_seq_pkg.sv | 27 ++
 rtl/shift_seq_ctrl.sv | 133 +++++++++++++
 tb/tb_shift_seq_ctrl.sv | 220 ++++++++++++++++++++++
 3 files changed

// File: rtl/shift_seq_pkg.sv
// Shared definitions for the shift-register command sequencer: command op
// codes, register mode-select values and the one-hot FSM state encoding.
package shift_seq_pkg;

  // Host command op codes carried on cmd_op.
  typedef enum logic [1:0] {
    OP_LOAD = 2'b00,
    OP_SHR  = 2'b01,
    OP_SHL  = 2'b10,
    OP_ROR  = 2'b11
  } op_e;

  // Mode select values understood by bi_shift_register.
  localparam logic [1:0] S_HOLD  = 2'b00;
  localparam logic [1:0] S_RIGHT = 2'b01;
  localparam logic [1:0] S_LEFT  = 2'b10;
  localparam logic [1:0] S_LOAD  = 2'b11;

  // One-hot controller states; the raw vector is exported on dbg_state.
  typedef enum logic [3:0] {
    ST_IDLE  = 4'b0001,
    ST_LOAD  = 4'b0010,
    ST_SHIFT = 4'b0100,
    ST_DONE  = 4'b1000
  } state_e;

endpackage

// File: rtl/shift_seq_ctrl.sv
// Command sequencer for a bi-directional shift register.
// Handshake: a command transfers on a rising clk edge where cmd_valid and
// cmd_ready are both high; cmd_ready is high only in IDLE, so a source
// presenting a command while busy must hold it until it is taken.
// Every output is decoded from registered state, latched operands and the
// register feedback reg_q; no cmd_* input reaches an output combinationally.
module shift_seq_ctrl
  import shift_seq_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int CNT_W = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [WIDTH-1:0] cmd_data,
  input  logic [CNT_W-1:0] cmd_count,
  input  logic [WIDTH-1:0] reg_q,
  output logic [1:0]       reg_s,
  output logic             reg_sr_in,
  output logic             reg_sl_in,
  output logic [WIDTH-1:0] reg_pdata,
  output logic             ser_out,
  output logic             ser_valid,
  output logic             busy,
  output logic             done,
  output logic [3:0]       dbg_state
);

  state_e           state_q, state_d;
  op_e              op_q, op_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             accept;

  // Only the end bits of the feedback are ever observed.
  logic unused_reg_q;
  assign unused_reg_q = ^reg_q;

  assign accept    = cmd_valid && (state_q == ST_IDLE);
  assign dbg_state = state_q;

  // State, operand latch and remaining-count registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      op_q    <= OP_LOAD;
      data_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      data_q  <= data_d;
      cnt_q   <= cnt_d;
    end
  end

  // Operand capture on acceptance; down-count once per shift cycle.
  always_comb begin
    op_d   = op_q;
    data_d = data_q;
    cnt_d  = cnt_q;
    if (accept) begin
      op_d   = op_e'(cmd_op);
      data_d = cmd_data;
      cnt_d  = cmd_count;
    end else if (state_q == ST_SHIFT) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  // Next-state logic and output decode.
  always_comb begin
    state_d   = state_q;
    cmd_ready = 1'b0;
    reg_s     = S_HOLD;
    reg_sr_in = 1'b0;
    reg_sl_in = 1'b0;
    reg_pdata = '0;
    ser_out   = 1'b0;
    ser_valid = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          if (op_e'(cmd_op) == OP_LOAD)  state_d = ST_LOAD;
          else if (cmd_count != '0)      state_d = ST_SHIFT;
          else                           state_d = ST_DONE;
        end
      end
      ST_LOAD: begin
        busy      = 1'b1;
        reg_s     = S_LOAD;
        reg_pdata = data_q;
        state_d   = ST_DONE;
      end
      ST_SHIFT: begin
        busy      = 1'b1;
        ser_valid = 1'b1;
        case (op_q)
          OP_SHL: begin
            reg_s     = S_LEFT;
            reg_sl_in = data_q[0];
            ser_out   = reg_q[WIDTH-1];
          end
          OP_ROR: begin
            // The LSB leaving the register re-enters at the MSB.
            reg_s     = S_RIGHT;
            reg_sr_in = reg_q[0];
            ser_out   = reg_q[0];
          end
          default: begin
            reg_s     = S_RIGHT;
            reg_sr_in = data_q[0];
            ser_out   = reg_q[0];
          end
        endcase
        if (cnt_q == CNT_W'(1)) state_d = ST_DONE;
      end
      ST_DONE: begin
        busy    = 1'b1;
        done    = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_shift_seq_ctrl.sv
// Bench for shift_seq_ctrl with a behavioural 4-bit bi-directional shift
// register attached to the reg_* controls and fed back on reg_q.
module tb_shift_seq_ctrl;
  import shift_seq_pkg::*;

  localparam int W = 4;
  localparam int CW = 3;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic [1:0]    cmd_op = 2'b00;
  logic [W-1:0]  cmd_data = '0;
  logic [CW-1:0] cmd_count = '0;
  logic [W-1:0]  reg_q;
  logic [1:0]    reg_s;
  logic          reg_sr_in, reg_sl_in;
  logic [W-1:0]  reg_pdata;
  logic          ser_out, ser_valid, busy, done;
  logic [3:0]    dbg_state;

  int n_tests = 0;
  int n_fail = 0;
  logic [0:0]   exp_q[$];   // expected ser_out bits, in order
  logic [W-1:0] mdl_q;      // expected register content between commands

  shift_seq_ctrl #(.WIDTH(W), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_data(cmd_data), .cmd_count(cmd_count), .reg_q(reg_q),
    .reg_s(reg_s), .reg_sr_in(reg_sr_in), .reg_sl_in(reg_sl_in),
    .reg_pdata(reg_pdata), .ser_out(ser_out), .ser_valid(ser_valid),
    .busy(busy), .done(done), .dbg_state(dbg_state)
  );

  // Clock.
  always #5 clk = ~clk;

  // Attached bi-directional shift register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) reg_q <= '0;
    else begin
      case (reg_s)
        2'b01:   reg_q <= {reg_sr_in, reg_q[W-1:1]};
        2'b10:   reg_q <= {reg_q[W-2:0], reg_sl_in};
        2'b11:   reg_q <= reg_pdata;
        default: reg_q <= reg_q;
      endcase
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  // Scoreboard: compare every valid serial bit against the expected queue.
  always @(negedge clk) begin
    if (ser_valid) begin
      if (exp_q.size() == 0) check_eq("ser_unexpected", 32'(ser_valid), 32'd0);
      else check_eq("ser_out", 32'(ser_out), 32'(exp_q.pop_front()));
    end
  end

  // Bounded wait for cmd_ready, at posedge+1.
  task automatic wait_ready();
    int w = 0;
    while (!cmd_ready && w < 20) begin
      @(posedge clk); #1; w++;
    end
    if (w == 20) check_eq("ready_timeout", 32'(cmd_ready), 32'd1);
  endtask

  // Issue one command and check it cycle by cycle against a bench model.
  task automatic run_cmd(input logic [1:0] op, input logic [W-1:0] data, input logic [CW-1:0] cnt);
    logic [W-1:0] m;
    logic [W-1:0] t;
    logic fill;
    m = mdl_q;
    fill = data[0];
    wait_ready();
    cmd_valid = 1'b1; cmd_op = op; cmd_data = data; cmd_count = cnt;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    if (op == OP_LOAD) begin
      @(negedge clk);
      check_eq("load_s", 32'(reg_s), 32'(S_LOAD));
      check_eq("load_pdata", 32'(reg_pdata), 32'(data));
      check_eq("load_busy_ready", {busy, cmd_ready, done}, 3'b100);
      @(posedge clk); #1;
      m = data;
    end else begin
      t = m;
      for (int i = 0; i < int'(cnt); i++) begin
        if (op == OP_SHL) begin exp_q.push_back(t[W-1]); t = {t[W-2:0], fill}; end
        else if (op == OP_ROR) begin exp_q.push_back(t[0]); t = {t[0], t[W-1:1]}; end
        else begin exp_q.push_back(t[0]); t = {fill, t[W-1:1]}; end
      end
      for (int i = 0; i < int'(cnt); i++) begin
        @(negedge clk);
        check_eq("shift_reg_q", 32'(reg_q), 32'(m));
        check_eq("shift_flags", {ser_valid, busy, done, cmd_ready}, 4'b1100);
        if (op == OP_SHL) begin
          check_eq("shl_ctl", {reg_s, reg_sr_in, reg_sl_in}, {S_LEFT, 1'b0, fill});
          m = {m[W-2:0], fill};
        end else if (op == OP_ROR) begin
          check_eq("ror_ctl", {reg_s, reg_sr_in, reg_sl_in}, {S_RIGHT, m[0], 1'b0});
          m = {m[0], m[W-1:1]};
        end else begin
          check_eq("shr_ctl", {reg_s, reg_sr_in, reg_sl_in}, {S_RIGHT, fill, 1'b0});
          m = {fill, m[W-1:1]};
        end
        @(posedge clk); #1;
      end
    end
    @(negedge clk);
    check_eq("done_pulse", {done, busy, ser_valid, cmd_ready}, 4'b1100);
    check_eq("done_s", 32'(reg_s), 32'(S_HOLD));
    check_eq("final_reg_q", 32'(reg_q), 32'(m));
    @(posedge clk); #1;
    check_eq("back_idle", {done, busy, cmd_ready}, 3'b001);
    mdl_q = m;
  endtask

  // Watchdog.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset.
    mdl_q = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_eq("rst_ready", 32'(cmd_ready), 32'd1);
    check_eq("rst_outs", {busy, done, reg_s, ser_valid, reg_sr_in, reg_sl_in, reg_pdata, ser_out}, 12'd0);
    check_eq("rst_state", 32'(dbg_state), 32'(ST_IDLE));
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // LOAD 1011, SHR 2 fill 1 (1101, 1110), reload, ROR 4.
    run_cmd(OP_LOAD, 4'b1011, 3'd0);
    run_cmd(OP_SHR, 4'b0001, 3'd2);
    run_cmd(OP_LOAD, 4'b1011, 3'd0);
    run_cmd(OP_ROR, 4'b0000, 3'd4);
    check_eq("ror_wrap", 32'(reg_q), 32'hB);

    // SHL count 0 with the next command held while busy.
    wait_ready();
    cmd_valid = 1'b1; cmd_op = OP_SHL; cmd_data = 4'b0001; cmd_count = 3'd0;
    @(posedge clk); #1;
    cmd_op = OP_LOAD; cmd_data = 4'b0101;   // held, must wait for IDLE
    @(negedge clk);
    check_eq("shl0_done", {done, cmd_ready, ser_valid}, 3'b100);
    check_eq("shl0_s", 32'(reg_s), 32'(S_HOLD));
    check_eq("shl0_reg_q", 32'(reg_q), 32'(mdl_q));
    @(posedge clk); #1;
    @(negedge clk);
    check_eq("held_not_taken", {cmd_ready, busy, reg_s}, 4'b1000);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    @(negedge clk);
    check_eq("held_load_s", 32'(reg_s), 32'(S_LOAD));
    check_eq("held_load_pdata", 32'(reg_pdata), 32'h5);
    @(posedge clk); #1;
    @(negedge clk);
    check_eq("held_load_done", 32'(done), 32'd1);
    check_eq("held_load_q", 32'(reg_q), 32'h5);
    @(posedge clk); #1;
    mdl_q = 4'h5;

    // Counts beyond the register width.
    run_cmd(OP_SHR, 4'b0000, 3'd7);
    run_cmd(OP_SHL, 4'b0001, 3'd6);
    run_cmd(OP_ROR, 4'b0000, 3'd7);

    // Random commands.
    repeat (8) run_cmd(2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)), 3'($urandom_range(0, 7)));

    // Reset in the second cycle of SHR count 5.
    run_cmd(OP_LOAD, 4'b1001, 3'd0);
    cmd_valid = 1'b1; cmd_op = OP_SHR; cmd_data = 4'b0000; cmd_count = 3'd5;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    exp_q.push_back(1'b1);
    @(negedge clk);
    check_eq("mid_shift", {ser_valid, busy}, 2'b11);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    check_eq("mid_rst_state", 32'(dbg_state), 32'(ST_IDLE));
    check_eq("mid_rst_outs", {cmd_ready, busy, done, reg_s, ser_valid}, 6'b100000);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_eq("mid_rst_no_done", {done, busy}, 2'b00);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    exp_q.delete();
    mdl_q = '0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check_eq("post_rst_no_done", {done, busy}, 2'b00);
    end
    @(posedge clk); #1;
    run_cmd(OP_LOAD, 4'b0110, 3'd0);
    check_eq("final_load", 32'(reg_q), 32'h6);

    check_eq("ser_queue_empty", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
